// File: rtl/window_3x3.sv
// Streaming 3x3 neighbourhood generator for raster-order pixels.
// Two line buffers feed a 3x3 register window; outputs are registered.
module window_3x3 #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int PIX_W  = 8,
  parameter int XW     = 10
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               IN_VALID,
  input  logic               IN_SOF,
  input  logic [PIX_W-1:0]   IN_PIXEL,
  output logic               OUT_VALID,
  output logic [9*PIX_W-1:0] OUT_WINDOW,
  output logic [XW-1:0]      OUT_X,
  output logic [XW-1:0]      OUT_Y
);

  localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [XW-1:0] XLAST = XW'(WIDTH - 1);
  localparam logic [XW-1:0] YLAST = XW'(HEIGHT - 1);
  localparam int P = PIX_W;

  logic [XW-1:0]    x_q, x_d;
  logic [XW-1:0]    y_q, y_d;
  logic [XW-1:0]    cx, cy;
  logic             acc;
  logic             emit;
  logic [AW-1:0]    addr;
  logic [P-1:0]     top_px, mid_px;
  logic [P-1:0]     lb0_q [WIDTH];
  logic [P-1:0]     lb1_q [WIDTH];
  logic [9*P-1:0]   win_q, win_d;
  logic             valid_q;
  logic [9*P-1:0]   owin_q;
  logic [XW-1:0]    ox_q, oy_q;

  // SOF overrides the counters so this pixel is (0,0)
  always_comb begin
    acc    = IN_VALID && !RESET;
    cx     = IN_SOF ? '0 : x_q;
    cy     = IN_SOF ? '0 : y_q;
    addr   = cx[AW-1:0];
    top_px = lb0_q[addr];
    mid_px = lb1_q[addr];
    x_d    = x_q;
    y_d    = y_q;
    if (IN_VALID) begin
      if (cx == XLAST) begin
        x_d = '0;
        y_d = (cy == YLAST) ? '0 : cy + XW'(1);
      end else begin
        x_d = cx + XW'(1);
        y_d = cy;
      end
    end
    win_d = {IN_PIXEL, win_q[8*P +: P], win_q[7*P +: P],
             mid_px,   win_q[5*P +: P], win_q[4*P +: P],
             top_px,   win_q[2*P +: P], win_q[1*P +: P]};
    emit  = IN_VALID && (cx >= XW'(2)) && (cy >= XW'(2));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      x_q     <= '0;
      y_q     <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      owin_q  <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= emit;
      if (IN_VALID) begin
        win_q <= win_d;
      end
      if (emit) begin
        owin_q <= win_d;
        ox_q   <= cx - XW'(1);
        oy_q   <= cy - XW'(1);
      end
    end
  end

  // Read-before-write: lb0 takes the row that lb1 held
  always_ff @(posedge CLK) begin
    if (acc) begin
      lb0_q[addr] <= mid_px;
      lb1_q[addr] <= IN_PIXEL;
    end
  end

  assign OUT_VALID  = valid_q;
  assign OUT_WINDOW = owin_q;
  assign OUT_X      = ox_q;
  assign OUT_Y      = oy_q;

endmodule

// File: tb/tb_window_3x3.sv
// Bench for window_3x3: 4x4 and 3x3 builds driven together,
// checked every cycle against an image-array model.
module tb_window_3x3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       v   = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] pix = '0;

  logic        ov4, ov3;
  logic [71:0] ow4, ow3;
  logic [9:0]  ox4, oy4, ox3, oy3;

  window_3x3 #(.WIDTH(4), .HEIGHT(4), .PIX_W(8), .XW(10)) dut4 (
    .CLK(clk), .RESET(rst), .IN_VALID(v), .IN_SOF(sof),
    .IN_PIXEL(pix), .OUT_VALID(ov4), .OUT_WINDOW(ow4),
    .OUT_X(ox4), .OUT_Y(oy4)
  );

  window_3x3 #(.WIDTH(3), .HEIGHT(3), .PIX_W(8), .XW(10)) dut3 (
    .CLK(clk), .RESET(rst), .IN_VALID(v), .IN_SOF(sof),
    .IN_PIXEL(pix), .OUT_VALID(ov3), .OUT_WINDOW(ow3),
    .OUT_X(ox3), .OUT_Y(oy3)
  );

  int checks = 0;
  int failures = 0;

  int          mx [2];
  int          my [2];
  logic [7:0]  img [2][16][16];
  logic        ev [2];
  logic [71:0] ew [2];
  int          ex [2];
  int          ey [2];
  bit          armed = 0;
  bit          gapchk = 0;
  logic        pv4 = 1'b0;

  logic [71:0] c4w[$];
  int          c4x[$], c4y[$];
  logic [71:0] c3w[$];
  int          c3x[$], c3y[$];
  logic [71:0] p2w[$];

  function automatic void chk(string nm, logic [71:0] act,
                              logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Model: remember every pixel at its (x,y), build windows from it
  function automatic void step(int i, int W, int H);
    int x, y;
    if (rst) begin
      mx[i] = 0; my[i] = 0;
      ev[i] = 0; ew[i] = '0; ex[i] = 0; ey[i] = 0;
    end else if (v) begin
      x = sof ? 0 : mx[i];
      y = sof ? 0 : my[i];
      img[i][y][x] = pix;
      if (x >= 2 && y >= 2) begin
        ev[i] = 1;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            ew[i][8*(3*r+c) +: 8] = img[i][y-2+r][x-2+c];
        ex[i] = x - 1;
        ey[i] = y - 1;
      end else begin
        ev[i] = 0;
      end
      x++;
      if (x == W) begin
        x = 0;
        y++;
        if (y == H) y = 0;
      end
      mx[i] = x;
      my[i] = y;
    end else begin
      ev[i] = 0;
    end
  endfunction

  always @(posedge clk) begin
    step(0, 4, 4);
    step(1, 3, 3);
    armed <= 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("valid4", ov4, ev[0]);
      chk("win4", ow4, ew[0]);
      chk("x4", ox4, ex[0]);
      chk("y4", oy4, ey[0]);
      chk("valid3", ov3, ev[1]);
      chk("win3", ow3, ew[1]);
      chk("x3", ox3, ex[1]);
      chk("y3", oy3, ey[1]);
      if (ov4) begin
        c4w.push_back(ow4); c4x.push_back(ox4); c4y.push_back(oy4);
      end
      if (ov3) begin
        c3w.push_back(ow3); c3x.push_back(ox3); c3y.push_back(oy3);
      end
      if (gapchk) chk("gap_consec", ov4 && pv4, 0);
      pv4 = ov4;
    end
  end

  task automatic cyc(bit r, bit vv, bit ss, logic [7:0] p);
    rst = r; v = vv; sof = ss; pix = p;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(int W, int H, int base, bit s, bit gaps);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        cyc(0, 1, s && x == 0 && y == 0, 8'(base + 16*y + x));
        if (gaps) cyc(0, 0, 0, 8'hFF);
      end
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
  endtask

  task automatic clr();
    c4w.delete(); c4x.delete(); c4y.delete();
    c3w.delete(); c3x.delete(); c3y.delete();
  endtask

  int cxs [4] = '{1, 2, 1, 2};
  int cys [4] = '{1, 1, 2, 2};

  initial begin
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 8'h55);
    chk("rst_valid", ov4, 0);
    chk("rst_win", ow4, 0);
    chk("rst_x", ox4, 0);
    chk("rst_y", oy4, 0);

    // Continuous 4x4 frame
    clr();
    frame(4, 4, 0, 1, 0);
    chk("f1_count", c4w.size(), 4);
    if (c4w.size() == 4) begin
      chk("f1_win0", c4w[0], 72'h222120121110020100);
      for (int i = 0; i < 4; i++) begin
        chk("f1_cx", c4x[i], cxs[i]);
        chk("f1_cy", c4y[i], cys[i]);
      end
    end
    p2w = c4w;

    // Same frame with a bubble after every pixel
    clr();
    gapchk = 1;
    frame(4, 4, 0, 1, 1);
    gapchk = 0;
    chk("gap_count", c4w.size(), 4);
    if (c4w.size() == 4 && p2w.size() == 4)
      for (int i = 0; i < 4; i++) chk("gap_win", c4w[i], p2w[i]);

    // Back-to-back frames, implicit frame start on the second
    clr();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        cyc(0, 1, x == 0 && y == 0, 8'(16*y + x));
    frame(4, 4, 8'h80, 0, 0);
    chk("b2b_count", c4w.size(), 8);
    if (c4w.size() == 8) begin
      chk("b2b_win", c4w[4], 72'hA2A1A0929190828180);
      chk("b2b_cx", c4x[4], 1);
      chk("b2b_cy", c4y[4], 1);
      for (int i = 4; i < 8; i++)
        for (int k = 0; k < 9; k++)
          chk("b2b_nostale", c4w[i][8*k+7], 1);
    end

    // Abandon at (2,1) with a new SOF
    clr();
    cyc(0, 1, 1, 8'h00);
    cyc(0, 1, 0, 8'h01);
    cyc(0, 1, 0, 8'h02);
    cyc(0, 1, 0, 8'h03);
    cyc(0, 1, 0, 8'h10);
    cyc(0, 1, 0, 8'h11);
    frame(4, 4, 8'h40, 1, 0);
    chk("sof_count", c4w.size(), 4);
    if (c4w.size() == 4) begin
      chk("sof_win", c4w[0], 72'h626160525150424140);
      chk("sof_last", c4w[3], 72'h737271636261535251);
    end

    // Reset one cycle after (3,2), colliding with a valid pixel
    clr();
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++)
        cyc(0, 1, x == 0 && y == 0, 8'(16*y + x));
    cyc(1, 1, 0, 8'hEE);
    chk("mrst_valid", ov4, 0);
    chk("mrst_win", ow4, 0);
    frame(4, 4, 8'h20, 0, 0);
    chk("mrst_count", c4w.size(), 6);
    if (c4w.size() == 6)
      chk("mrst_win2", c4w[2], 72'h424140323130222120);

    // Random traffic
    for (int n = 0; n < 800; n++)
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 40) == 0), 8'($urandom));

    // 3x3 build: one window per frame
    cyc(1, 0, 0, 0);
    clr();
    frame(3, 3, 0, 1, 0);
    chk("w3_count", c3w.size(), 1);
    if (c3w.size() == 1) begin
      chk("w3_cx", c3x[0], 1);
      chk("w3_cy", c3y[0], 1);
      chk("w3_centre", c3w[0][39:32], 8'h11);
      chk("w3_win", c3w[0], 72'h222120121110020100);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
